array_stream_reader: RTL and testbench
======================================

# array_stream_reader

Consumer for the constant-array driver that emits a 5×5 array of 5-bit words. Word i carries value i. The block captures a whole array on a load handshake and replays its elements one per cycle over a valid/ready stream. As each element is transferred, it is checked against its expected value (its own index) and mismatches are counted. The block sits between an array-producing module and any serial consumer or checker in the design.

## Interface
- N, default 5: number of array elements.
- WIDTH, default 5: bits per element.
- IW, default clog2(N) = 3: index width.
- CW, default clog2(N+1) = 3: mismatch-counter width.

Ports:
- CLK, input, 1: clock. All state updates on the rising edge.
- RESET, input, 1: synchronous, active-high reset.
- I, input, [WIDTH-1:0] × [N-1:0] (unpacked array): array to capture.
- load_valid, input, 1: I is valid this cycle.
- load_ready, output, 1: block accepts I this cycle.
- out_data, output, WIDTH: current element.
- out_index, output, IW: index of the current element.
- out_valid, output, 1: out_data/out_index valid.
- out_ready, input, 1: downstream accepts the element.
- out_last, output, 1: current element is index N-1.
- mismatch_count, output, CW: mismatches in the current or most recent array.
- done, output, 1: one-cycle pulse after the last element transfers.

## Operation
- States:
  - IDLE: out_valid=0, load_ready=1.
  - STREAM: out_valid=1.
- Load accept (load_valid & load_ready):
  - buf[k] <= I[k] for all k.
  - idx <= 0, mismatch_count <= 0, state <= STREAM.
- While in STREAM:
  - out_data = buf[idx], out_index = idx, out_last = (idx == N-1).
- Transfer (out_valid & out_ready):
  - Compare buf[idx] with idx, zero-extended or truncated to WIDTH.
  - On inequality, mismatch_count increments, saturating at N.
  - If not out_last: idx <= idx+1.
  - If out_last: done <= 1 next cycle. Then state <= IDLE, unless a load is accepted the same cycle.
- load_ready = (state==IDLE) | (state==STREAM & out_last & out_ready). This path is combinational from out_ready.
- Simultaneous last transfer and load accept:
  - The new array is captured, idx <= 0, state stays STREAM.
  - mismatch_count <= 0. The final comparison of the old array is discarded from the count.
  - done still pulses.
- No transfer (out_ready=0): out_data, out_index and idx hold. load_ready=0 in STREAM except on a last-beat transfer.
- mismatch_count holds its value in IDLE until the next load accept.
- Reset values: state=IDLE, idx=0, buf all 0, mismatch_count=0, done=0, out_valid=0, load_ready=1 (combinational from state), out_last=0.
- RESET asserted mid-STREAM: the next cycle is IDLE with all registers at reset values. No done pulse. The in-flight array is discarded.
- load_valid while load_ready=0 is ignored. The producer must hold it.

## Timing
- Load accepted at cycle T: out_valid=1 with element 0 at T+1.
- Element k: earliest at T+1+k.
- Last transfer at cycle L: done=1 at L+1 only.
- Throughput:
  - Without overlap: N elements per N+1 cycles.
  - With a load accepted on the last beat: N elements per N cycles (back-to-back).
- mismatch_count reflects a transfer at cycle t from cycle t+1.

## Test plan
- Nominal array:
  - Stimulus: reset; I = {0,1,2,3,4}, load at cycle 2, out_ready=1 continuously.
  - Response: out_data 0,1,2,3,4 at cycles 3–7; out_last only at cycle 7; done at cycle 8; mismatch_count=0; load_ready=1 from cycle 8.
- Mismatches:
  - Stimulus: I = {0,7,2,31,4}.
  - Response: stream 0,7,2,31,4; mismatch_count steps 0→1 after the index-1 transfer and 1→2 after the index-3 transfer; final value 2.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles while index 2 is presented.
  - Response: out_data=2 and out_index=2 held for 3 cycles; load_ready=0 throughout; total 8 cycles from first valid to last transfer.
- Back-to-back arrays:
  - Stimulus: second array {4,3,2,1,0} held on load_valid, accepted on the first array's last beat.
  - Response: stream 0,1,2,3,4,4,3,2,1,0 with no gap; done pulses after the first array; mismatch_count reset, then ends at 4 (indices 0,1,3,4 mismatch).
- Reset mid-stream:
  - Stimulus: RESET at the index-2 transfer cycle.
  - Response: next cycle out_valid=0, mismatch_count=0, load_ready=1; no done pulse; a fresh load then streams from index 0.
- Saturation:
  - Stimulus: all elements 31.
  - Response: mismatch_count ends at 5 and does not wrap.

Source files
------------

// File: rtl/array_stream_reader.sv
// rtl/array_stream_reader.sv - captures an N-element array on a load handshake and replays it as a stream
// Each transferred element is checked against its own index; mismatches are counted, saturating at N.
module array_stream_reader #(
  parameter int N     = 5,
  parameter int WIDTH = 5,
  parameter int IW    = $clog2(N),
  parameter int CW    = $clog2(N + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I [N-1:0],
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CW-1:0]    mismatch_count,
  output logic             done
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] elem_q [N-1:0];
  logic [WIDTH-1:0] elem_d [N-1:0];
  logic [CW-1:0]    mm_q, mm_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cur_data;
  logic             is_last;
  logic             xfer;
  logic             load_acc;

  // Explicit mux keeps out-of-range index values (N not a power of two) well defined.
  always_comb begin
    cur_data = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) cur_data = elem_q[k];
    end
  end

  assign is_last    = (state_q == S_STREAM) && (idx_q == IW'(N - 1));
  assign out_valid  = (state_q == S_STREAM);
  assign xfer       = out_valid & out_ready;
  assign load_ready = (state_q == S_IDLE) | (is_last & out_ready);
  assign load_acc   = load_valid & load_ready;

  assign out_data       = cur_data;
  assign out_index      = idx_q;
  assign out_last       = is_last;
  assign mismatch_count = mm_q;
  assign done           = done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    elem_d  = elem_q;
    mm_d    = mm_q;
    done_d  = xfer & is_last;
    if (xfer) begin
      if ((cur_data != WIDTH'(idx_q)) && (mm_q != CW'(N))) mm_d = mm_q + 1'b1;
      if (is_last) state_d = S_IDLE;
      else         idx_d   = idx_q + 1'b1;
    end
    // A load on the final beat overrides the old array's last comparison.
    if (load_acc) begin
      elem_d  = I;
      idx_d   = '0;
      mm_d    = '0;
      state_d = S_STREAM;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mm_q    <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < N; k++) elem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      done_q  <= done_d;
      elem_q  <= elem_d;
    end
  end

endmodule

// File: tb/tb_array_stream_reader.sv
// tb/tb_array_stream_reader.sv - directed and randomized checks of array_stream_reader against an index-count model
module tb_array_stream_reader;

  logic       CLK;
  logic       RESET;
  logic [4:0] I [4:0];
  logic       load_valid;
  logic       load_ready;
  logic [4:0] out_data;
  logic [2:0] out_index;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [2:0] mismatch_count;
  logic       done;

  int total = 0;
  int bad   = 0;

  array_stream_reader dut (
    .CLK(CLK), .RESET(RESET), .I(I), .load_valid(load_valid), .load_ready(load_ready),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .mismatch_count(mismatch_count), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set5(output logic [4:0] a [4:0], input int v0, v1, v2, v3, v4);
    a[0] = 5'(v0); a[1] = 5'(v1); a[2] = 5'(v2); a[3] = 5'(v3); a[4] = 5'(v4);
  endtask

  // Reference: number of elements before position k whose value differs from their index, capped at 5.
  function automatic int mm_upto(input logic [4:0] a [4:0], input int k);
    int c = 0;
    for (int j = 0; j < k; j++) if (a[j] != 5'(j)) c++;
    return (c > 5) ? 5 : c;
  endfunction

  task automatic rand_arr(output logic [4:0] a [4:0]);
    for (int j = 0; j < 5; j++)
      a[j] = ($urandom_range(0, 1) == 1) ? 5'(j) : 5'($urandom_range(0, 31));
  endtask

  // Called at a negedge while idle; returns at the negedge where element 0 is presented.
  task automatic load_arr(input logic [4:0] a [4:0]);
    I = a;
    load_valid = 1'b1;
    #1 chk("load_ready_idle", load_ready, 1);
    @(posedge CLK); @(negedge CLK);
    load_valid = 1'b0;
  endtask

  task automatic stream_arr(input logic [4:0] a [4:0], input bit chain, input logic [4:0] nxt [4:0],
                            input bit done_first, input int stall_idx, input int stall_n,
                            input int pct, output int cycles);
    int  k   = 0;
    int  st  = 0;
    int  cyc = 0;
    bit  rdy;
    while (k < 5 && cyc < 100) begin
      chk("out_valid", out_valid, 1);
      chk("out_index", out_index, k);
      chk("out_data", out_data, a[k]);
      chk("out_last", out_last, k == 4);
      chk("mismatch_count", mismatch_count, mm_upto(a, k));
      chk("done_in_stream", done, (cyc == 0) && done_first);
      if (k == stall_idx && st < stall_n) begin
        rdy = 1'b0;
        st++;
      end else if (pct > 0) begin
        rdy = ($urandom_range(0, 99) >= pct);
      end else begin
        rdy = 1'b1;
      end
      out_ready  = rdy;
      load_valid = chain;
      if (chain) I = nxt;
      #1 chk("load_ready_stream", load_ready, rdy && (k == 4));
      @(posedge CLK); @(negedge CLK);
      cyc++;
      if (rdy) k++;
    end
    chk("stream_complete", k, 5);
    load_valid = 1'b0;
    out_ready  = 1'b0;
    cycles     = cyc;
  endtask

  task automatic idle_checks(input int exp_mm);
    chk("done_pulse", done, 1);
    chk("idle_valid", out_valid, 0);
    chk("idle_last", out_last, 0);
    chk("idle_load_ready", load_ready, 1);
    chk("final_mismatch", mismatch_count, exp_mm);
    @(negedge CLK);
    chk("done_single", done, 0);
    chk("mismatch_hold", mismatch_count, exp_mm);
  endtask

  initial begin
    logic [4:0] a0 [4:0];
    logic [4:0] a1 [4:0];
    logic [4:0] cur [4:0];
    logic [4:0] nxt [4:0];
    int         cyc;
    bit         ch;
    bit         df;

    RESET = 1'b1; load_valid = 1'b0; out_ready = 1'b0;
    for (int j = 0; j < 5; j++) I[j] = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_mismatch", mismatch_count, 0);
    chk("rst_done", done, 0);
    chk("rst_last", out_last, 0);

    // Nominal array
    set5(a0, 0, 1, 2, 3, 4);
    set5(a1, 0, 0, 0, 0, 0);
    load_arr(a0);
    stream_arr(a0, 1'b0, a1, 1'b0, -1, 0, 0, cyc);
    chk("nominal_cycles", cyc, 5);
    idle_checks(0);

    // Mismatches
    set5(a0, 0, 7, 2, 31, 4);
    load_arr(a0);
    stream_arr(a0, 1'b0, a1, 1'b0, -1, 0, 0, cyc);
    idle_checks(2);

    // Backpressure at index 2
    set5(a0, 0, 1, 2, 3, 4);
    load_arr(a0);
    stream_arr(a0, 1'b0, a1, 1'b0, 2, 3, 0, cyc);
    chk("backpressure_cycles", cyc, 8);
    idle_checks(0);

    // Back-to-back arrays, second held on load_valid during the first
    set5(a0, 0, 1, 2, 3, 4);
    set5(a1, 4, 3, 2, 1, 0);
    load_arr(a0);
    stream_arr(a0, 1'b1, a1, 1'b0, -1, 0, 0, cyc);
    chk("b2b_first_cycles", cyc, 5);
    stream_arr(a1, 1'b0, a0, 1'b1, -1, 0, 0, cyc);
    chk("b2b_second_cycles", cyc, 5);
    idle_checks(4);

    // Reset during the index-2 transfer
    set5(a0, 0, 7, 2, 31, 4);
    load_arr(a0);
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("pre_rst_index", out_index, 2);
    chk("pre_rst_mismatch", mismatch_count, 1);
    RESET = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RESET = 1'b0;
    out_ready = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_mismatch", mismatch_count, 0);
    chk("midrst_load_ready", load_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_data", out_data, 0);
    @(negedge CLK);
    chk("midrst_no_done", done, 0);
    set5(a0, 3, 1, 2, 3, 4);
    load_arr(a0);
    stream_arr(a0, 1'b0, a1, 1'b0, -1, 0, 0, cyc);
    idle_checks(1);

    // Saturation
    set5(a0, 31, 31, 31, 31, 31);
    load_arr(a0);
    stream_arr(a0, 1'b0, a1, 1'b0, -1, 0, 0, cyc);
    idle_checks(5);

    // Randomized arrays, random backpressure, random chaining
    df = 1'b0;
    rand_arr(cur);
    load_arr(cur);
    for (int it = 0; it < 8; it++) begin
      rand_arr(nxt);
      ch = (it < 7) && ($urandom_range(0, 1) == 1);
      stream_arr(cur, ch, nxt, df, -1, 0, 30, cyc);
      if (!ch) begin
        idle_checks(mm_upto(cur, 5));
        if (it < 7) load_arr(nxt);
      end
      df  = ch;
      cur = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
